// File: rtl/logo_scroll_ctrl_pkg.sv
// logo_scroll_ctrl_pkg: shared types and widths for the logo scroll controller
package logo_scroll_ctrl_pkg;
  localparam int LOGO_DELT_W = 11;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_MOVE_R,
    S_PAUSE_R,
    S_MOVE_L,
    S_PAUSE_L
  } state_t;
endpackage

// File: rtl/logo_scroll_ctrl_edge.sv
// logo_scroll_ctrl_edge: vsync falling-edge detector producing the frame tick
module logo_scroll_ctrl_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_vsync,
  output logic o_tick,
  output logic o_frame_tick
);
  logic r_vsync_d, r_armed, r_tick;
  // r_armed blocks a false edge when vsync is already low at reset release
  assign o_tick = r_vsync_d & r_armed & ~i_vsync;
  assign o_frame_tick = r_tick;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_vsync_d <= 1'b1;
      r_armed <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
      r_armed <= r_armed | i_vsync;
      r_tick <= o_tick;
    end
endmodule

// File: rtl/logo_scroll_ctrl.sv
// logo_scroll_ctrl: frame-synchronous bounce animation for the VGA logo overlay
module logo_scroll_ctrl
  import logo_scroll_ctrl_pkg::*;
#(
  parameter int STEP = 2,
  parameter int MAX_DELT = 200,
  parameter int PAUSE_FRAMES = 30,
  parameter int START_FRAMES = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vsync,
  input  logic                   run,
  output logic [LOGO_DELT_W-1:0] delt,
  output logic                   enble,
  output logic                   dir,
  output logic                   frame_tick
);
  localparam int DW = LOGO_DELT_W;
  localparam logic [DW:0] STEP_X = STEP[DW:0];
  localparam logic [DW:0] MAX_X = MAX_DELT[DW:0];
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_FRAMES - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
  state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [DW-1:0] r_delt, w_delt, w_up, w_dn;
  logic [DW:0] w_sum;
  logic r_enble, w_enble, r_dir, w_dir, w_tick;
  logo_scroll_ctrl_edge u_edge (
    .clk         (clk),
    .rst         (rst),
    .i_vsync     (vsync),
    .o_tick      (w_tick),
    .o_frame_tick(frame_tick)
  );
  // one bit of headroom so the clamp sees the true sum
  assign w_sum = {1'b0, r_delt} + STEP_X;
  assign w_up = (w_sum >= MAX_X) ? MAX_X[DW-1:0] : w_sum[DW-1:0];
  assign w_dn = ({1'b0, r_delt} <= STEP_X) ? '0 : r_delt - STEP_X[DW-1:0];
  assign delt = r_delt;
  assign enble = r_enble;
  assign dir = r_dir;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_delt = r_delt;
    w_enble = r_enble;
    w_dir = r_dir;
    case (r_state)
      S_IDLE: begin
        w_delt = '0;
        w_enble = run;
        w_dir = 1'b0;
        w_cnt = '0;
        w_state = run ? S_START : S_IDLE;
      end
      S_START: begin
        w_cnt = (r_cnt == START_LAST) ? '0 : r_cnt + 1'b1;
        w_state = (r_cnt == START_LAST) ? S_MOVE_R : S_START;
      end
      S_MOVE_R: begin
        w_delt = w_up;
        w_state = (w_up == MAX_X[DW-1:0]) ? S_PAUSE_R : S_MOVE_R;
      end
      S_PAUSE_R: begin
        w_cnt = (r_cnt == PAUSE_LAST) ? '0 : r_cnt + 1'b1;
        w_dir = (r_cnt == PAUSE_LAST) ? 1'b1 : r_dir;
        w_state = (r_cnt == PAUSE_LAST) ? S_MOVE_L : S_PAUSE_R;
      end
      S_MOVE_L: begin
        w_delt = w_dn;
        w_state = (w_dn == '0) ? S_PAUSE_L : S_MOVE_L;
      end
      S_PAUSE_L: begin
        w_cnt = (r_cnt == PAUSE_LAST) ? '0 : r_cnt + 1'b1;
        w_dir = (r_cnt == PAUSE_LAST) ? 1'b0 : r_dir;
        w_state = (r_cnt == PAUSE_LAST) ? S_MOVE_R : S_PAUSE_L;
      end
      default: w_state = S_IDLE;
    endcase
    if (!run && r_state != S_IDLE) begin
      w_state = S_IDLE;
      w_cnt = '0;
      w_delt = '0;
      w_enble = 1'b0;
      w_dir = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_delt <= '0;
      r_enble <= 1'b0;
      r_dir <= 1'b0;
    end else if (w_tick) begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_delt <= w_delt;
      r_enble <= w_enble;
      r_dir <= w_dir;
    end
endmodule
